// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter (DATA_BITS, PARITY, STOP_BITS).
// Optional input FIFO enabled by defining the macro UART_TX_FIFO_EN.
// tx_pin is registered from the current FSM state, so the line lags the
// state by exactly one clock; send_done marks the last STOP-state clock.
module uart_tx_cfg #(
    parameter int CLK_FRE    = 50,
    parameter int UART_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 send_en,
    input  logic [DATA_BITS-1:0] send_data,
    output logic                 send_busy,
    output logic                 send_done,
    output logic                 tx_pin
);

    localparam int BIT_CLKS = CLK_FRE * 1000000 / UART_RATE;
    localparam int CNT_W    = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
    localparam int IDX_W    = $clog2(DATA_BITS);

    // Reject parameter sets that cannot form a legal frame.
    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || BIT_CLKS < 2) begin : g_bad_cfg
        $error("uart_tx_cfg: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;

    logic                 load;
    logic [DATA_BITS-1:0] load_word;
    logic                 bit_last;
    logic                 done_arm;
    logic                 par_bit;

    assign bit_last = (cnt == CNT_W'(BIT_CLKS - 1));
    assign done_arm = (cnt == CNT_W'(BIT_CLKS - 2));
    assign par_bit  = (PARITY == 1) ? ~^shreg : ^shreg;

`ifdef UART_TX_FIFO_EN
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of two in 2..16");
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     count;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    assign full      = (count == (FIFO_AW + 1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push      = send_en && !full;
    assign pop       = (state == S_IDLE) && !empty;
    assign load      = pop;
    assign load_word = mem[rd_ptr];
    assign send_busy = full;

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= send_data;
    end
`else
    if (FIFO_DEPTH < 1) begin : g_bad_fifo
        $error("uart_tx_cfg: FIFO_DEPTH must be positive");
    end

    assign load      = (state == S_IDLE) && send_en;
    assign load_word = send_data;
    assign send_busy = (state != S_IDLE);
`endif

    // Frame sequencer; tx_pin and send_done are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            tx_pin    <= 1'b1;
            send_done <= 1'b0;
        end else begin
            send_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx_pin   <= 1'b1;
                    cnt      <= '0;
                    idx      <= '0;
                    stop_idx <= 1'b0;
                    if (load) begin
                        shreg <= load_word;
                        state <= S_START;
                    end
                end
                S_START: begin
                    tx_pin <= 1'b0;
                    if (bit_last) begin
                        cnt   <= '0;
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    tx_pin <= shreg[idx];
                    if (bit_last) begin
                        cnt <= '0;
                        if (idx == IDX_W'(DATA_BITS - 1)) begin
                            idx   <= '0;
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    tx_pin <= par_bit;
                    if (bit_last) begin
                        cnt   <= '0;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    tx_pin <= 1'b1;
                    if (done_arm && stop_idx == 1'(STOP_BITS - 1))
                        send_done <= 1'b1;
                    if (bit_last) begin
                        cnt <= '0;
                        if (stop_idx == 1'(STOP_BITS - 1)) begin
                            stop_idx <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx_pin <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
